stage_execute_vec: RTL and testbench
====================================

# stage_execute_vec

Parametrised execute stage for the vector core, successor to the fixed 128-bit execute stage. It computes LANES independent LANE_W-bit ALU lanes and resolves branches on lane 0. It adds a multi-cycle multiply with a busy/stall handshake toward the hazard unit. It sits between the decode/EX register and the MEM stage and owns the EX/MEM pipeline register.

## Interface
Parameters:
- LANES, 4, number of lanes (≥1)
- LANE_W, 32, lane width; W = LANES*LANE_W
- MUL_LAT, 3, multiply latency in clk edges (≥2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- mem_clear, mem_stall  in  1  flush / hold EX/MEM register
- ex_instr  in  32  debug instruction
- ex_reg_write, ex_mem_write, ex_mem_read, ex_jump, ex_jump_cond, ex_vector_op  in  1  control
- ex_jump_cond_type  in  3  branch condition
- ex_alu_control  in  4  lane op
- ex_alu_src_op1  in  1  1: forwarded rd1, 0: zero
- ex_alu_src_op2  in  1  1: immediate, 0: forwarded rd2
- ex_pc_target_src  in  1  1: target = lane-0 result, 0: ex_pc + imm
- ex_result_src  in  2  result select, passed through
- ex_pc, ex_pc_plus_4, ex_imm_ext  in  32  PC, PC+4, immediate
- ex_rd1, ex_rd2  in  W  register operands
- ex_rd  in  5  destination
- wb_result  in  W  WB forward value
- ex_op1_forward, ex_op2_forward  in  2  00 regfile, 01 WB, 10 MEM
- mem_instr  out  32  registered
- mem_reg_write, mem_mem_write, mem_mem_read, mem_vector_op  out  1  registered
- mem_result_src  out  2  registered
- mem_alu_result, mem_write_data, mem_imm_ext  out  W  registered
- mem_pc_plus_4  out  32  registered
- mem_rd  out  5  registered
- ex_pc_src  out  1  branch/jump taken, combinational
- ex_pc_target  out  32  combinational
- ex_busy  out  1  to hazard unit; upstream holds all ex_* inputs while high

## Operation
- Operand forwarding:
  - Op1: 01 → wb_result; 10 → mem_alu_result.
  - Store data: 01 → wb_result; 10 → lane 0 of mem_alu_result broadcast to all lanes.
  - 00 → register operand.
- Scalar store data (ex_vector_op=0) is broadcast lane 0.
- op2 lane i = imm (every lane) when ex_alu_src_op2, else store-data lane i.
- Lane ops, per lane, modulo 2^LANE_W:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA (shift amount = op2[log2(LANE_W)-1:0])
  - 8 SLT, 9 SLTU (result 0/1)
  - 10 MUL (low LANE_W bits, multi-cycle)
  - others → 0
- ex_vector_op=0: only lane 0 is valid; lanes 1..LANES-1 of mem_alu_result are 0.
- Flags come from lane 0 computing op1−op2: Z, N, V, C (C=1 means no borrow).
- Branch types: 0 EQ Z, 1 NE !Z, 4 LT N^V, 5 GE !(N^V), 6 LTU !C, 7 GEU C; 2, 3 never taken.
- ex_pc_src = ((ex_jump_cond & cond) | ex_jump) & reset.
- mem_imm_ext = imm broadcast to all lanes.
- Multiply FSM, states IDLE and BUSY with a down-counter cnt:
  - IDLE & op==10 & !mem_clear: ex_busy=1. Capture op1/op2 for all lanes, go to BUSY with cnt=MUL_LAT-2, insert a bubble.
  - BUSY & cnt≠0: ex_busy=1, cnt--, insert a bubble. cnt decrements even under mem_stall.
  - BUSY & cnt=0: ex_busy=mem_stall. When !mem_stall, load the product plus the captured control into EX/MEM and go to IDLE.
  - Products use the captured operands only; forward sources may change while BUSY.
- Bubble: control outputs 0 and data 0, applied only when !mem_stall.
- mem_instr is loaded only with real instructions.

## Timing
- Reset low (async): all mem_* outputs 0, state IDLE, cnt 0, ex_busy 0, ex_pc_src 0.
- Register priority per edge: mem_clear > mem_stall (hold everything) > bubble > load.
- mem_clear clears all mem_* outputs, aborts a multiply (state → IDLE), and forces ex_busy to 0 that cycle.
- Non-MUL ops: 1-cycle latency; ex_busy=0.
- MUL: result appears in mem_alu_result MUL_LAT edges after the first EX cycle, plus any cycles mem_stall is held at cnt=0.
- A back-to-back MUL starts in the cycle after the load.
- MUL with a branch/jump is illegal; the branch still resolves from the current combinational operands.

## Test plan
- LANES=4, vector ADD, lane k: 0xFFFFFFFF + k → mem_alu_result lanes {0xFFFFFFFF, 0, 1, 2} after one edge.
- Scalar SUB 5−7 with op1 forwarded from MEM → lane 0 = 0xFFFFFFFE, lanes 1..3 = 0. BLT taken, ex_pc_target = ex_pc + imm.
- MUL_LAT=3, vector MUL 3×4 per lane:
  - ex_busy high for 2 cycles, bubbles in MEM, lanes = 12 at edge 3.
  - wb_result toggled mid-multiply does not change the result.
- MUL with mem_stall held high 4 cycles from the start → counter expires, result held; loads on the first edge with mem_stall low; ex_busy drops that cycle.
- mem_clear asserted during BUSY → outputs 0, IDLE, ex_busy 0 next cycle. Reset pulled low mid-MUL → all outputs 0 immediately.
- Scalar store, op2 forward=10, MEM lane0 = 0xA5 → mem_write_data = 0xA5 in all 4 lanes. BGEU with equal operands → ex_pc_src=1.

Source files
------------

// File: rtl/stage_execute_vec_if.sv
// rtl/stage_execute_vec_if.sv - EX-stage bundle: decode/EX inputs, forwarding, EX/MEM outputs
//
// Ports (by modport):
//   slave  (execute stage): receives ex_*, wb_result, mem_clear/mem_stall;
//                           drives mem_*, ex_pc_src, ex_pc_target, ex_busy
//   master (pipeline side): the mirror image
interface stage_execute_vec_if #(
    parameter int W = 128
);
    logic          mem_clear;
    logic          mem_stall;
    logic [31:0]   ex_instr;
    logic          ex_reg_write;
    logic          ex_mem_write;
    logic          ex_mem_read;
    logic          ex_jump;
    logic          ex_jump_cond;
    logic          ex_vector_op;
    logic [2:0]    ex_jump_cond_type;
    logic [3:0]    ex_alu_control;
    logic          ex_alu_src_op1;
    logic          ex_alu_src_op2;
    logic          ex_pc_target_src;
    logic [1:0]    ex_result_src;
    logic [31:0]   ex_pc;
    logic [31:0]   ex_pc_plus_4;
    logic [31:0]   ex_imm_ext;
    logic [W-1:0]  ex_rd1;
    logic [W-1:0]  ex_rd2;
    logic [4:0]    ex_rd;
    logic [W-1:0]  wb_result;
    logic [1:0]    ex_op1_forward;
    logic [1:0]    ex_op2_forward;

    logic [31:0]   mem_instr;
    logic          mem_reg_write;
    logic          mem_mem_write;
    logic          mem_mem_read;
    logic          mem_vector_op;
    logic [1:0]    mem_result_src;
    logic [W-1:0]  mem_alu_result;
    logic [W-1:0]  mem_write_data;
    logic [W-1:0]  mem_imm_ext;
    logic [31:0]   mem_pc_plus_4;
    logic [4:0]    mem_rd;
    logic          ex_pc_src;
    logic [31:0]   ex_pc_target;
    logic          ex_busy;

    modport slave (
        input  mem_clear, mem_stall, ex_instr, ex_reg_write, ex_mem_write, ex_mem_read,
               ex_jump, ex_jump_cond, ex_vector_op, ex_jump_cond_type, ex_alu_control,
               ex_alu_src_op1, ex_alu_src_op2, ex_pc_target_src, ex_result_src, ex_pc,
               ex_pc_plus_4, ex_imm_ext, ex_rd1, ex_rd2, ex_rd, wb_result,
               ex_op1_forward, ex_op2_forward,
        output mem_instr, mem_reg_write, mem_mem_write, mem_mem_read, mem_vector_op,
               mem_result_src, mem_alu_result, mem_write_data, mem_imm_ext,
               mem_pc_plus_4, mem_rd, ex_pc_src, ex_pc_target, ex_busy
    );

    modport master (
        output mem_clear, mem_stall, ex_instr, ex_reg_write, ex_mem_write, ex_mem_read,
               ex_jump, ex_jump_cond, ex_vector_op, ex_jump_cond_type, ex_alu_control,
               ex_alu_src_op1, ex_alu_src_op2, ex_pc_target_src, ex_result_src, ex_pc,
               ex_pc_plus_4, ex_imm_ext, ex_rd1, ex_rd2, ex_rd, wb_result,
               ex_op1_forward, ex_op2_forward,
        input  mem_instr, mem_reg_write, mem_mem_write, mem_mem_read, mem_vector_op,
               mem_result_src, mem_alu_result, mem_write_data, mem_imm_ext,
               mem_pc_plus_4, mem_rd, ex_pc_src, ex_pc_target, ex_busy
    );
endinterface

// File: rtl/stage_execute_vec.sv
// rtl/stage_execute_vec.sv - parametrised vector execute stage with multi-cycle multiply
//
// Ports:
//   clk    - clock
//   reset  - asynchronous active-low reset
//   bus    - stage_execute_vec_if.slave: ex_* operands/control, forwarding
//            selects and values in; EX/MEM register, branch resolution and
//            ex_busy (multiply stall toward the hazard unit) out
module stage_execute_vec #(
    parameter int LANES   = 4,
    parameter int LANE_W  = 32,
    parameter int MUL_LAT = 3
) (
    input  logic                clk,
    input  logic                reset,
    stage_execute_vec_if.slave  bus
);
    localparam int W   = LANES * LANE_W;
    localparam int SHW = (LANE_W > 1) ? $clog2(LANE_W) : 1;
    localparam int CW  = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 2);

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                           OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                           OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_MUL = 4'd10;

    typedef enum logic { S_IDLE, S_BUSY } state_t;

    function automatic logic [LANE_W-1:0] alu_lane(input logic [3:0] op,
                                                   input logic [LANE_W-1:0] a,
                                                   input logic [LANE_W-1:0] b);
        logic [LANE_W-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << b[SHW-1:0];
            OP_SRL:  r = a >> b[SHW-1:0];
            OP_SRA:  r = $signed(a) >>> b[SHW-1:0];
            OP_SLT:  r = LANE_W'($signed(a) < $signed(b));
            OP_SLTU: r = LANE_W'(a < b);
            default: r = '0;   // MUL is produced by the multiply path
        endcase
        return r;
    endfunction

    // operand selection
    logic [W-1:0]      op1_fwd, op1, sd_fwd, store_data, op2, imm_vec, alu_res, mul_res;
    logic [LANE_W-1:0] imm_lane;

    always_comb begin
        case (bus.ex_op1_forward)
            2'b01:   op1_fwd = bus.wb_result;
            2'b10:   op1_fwd = bus.mem_alu_result;
            default: op1_fwd = bus.ex_rd1;
        endcase
        op1 = bus.ex_alu_src_op1 ? op1_fwd : '0;

        case (bus.ex_op2_forward)
            2'b01:   sd_fwd = bus.wb_result;
            2'b10:   sd_fwd = {LANES{bus.mem_alu_result[LANE_W-1:0]}};
            default: sd_fwd = bus.ex_rd2;
        endcase
        store_data = bus.ex_vector_op ? sd_fwd : {LANES{sd_fwd[LANE_W-1:0]}};

        imm_lane = LANE_W'($signed(bus.ex_imm_ext));
        imm_vec  = {LANES{imm_lane}};
        op2      = bus.ex_alu_src_op2 ? imm_vec : store_data;
    end

    always_comb begin
        alu_res = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i == 0 || bus.ex_vector_op)
                alu_res[i*LANE_W +: LANE_W] = alu_lane(bus.ex_alu_control,
                                                       op1[i*LANE_W +: LANE_W],
                                                       op2[i*LANE_W +: LANE_W]);
        end
    end

    // branch resolution on lane 0 (op1 - op2)
    logic [LANE_W:0] diff;
    logic            flag_z, flag_n, flag_v, flag_c, cond;

    always_comb begin
        diff   = {1'b0, op1[LANE_W-1:0]} - {1'b0, op2[LANE_W-1:0]};
        flag_z = (diff[LANE_W-1:0] == '0);
        flag_n = diff[LANE_W-1];
        flag_v = (op1[LANE_W-1] != op2[LANE_W-1]) && (diff[LANE_W-1] != op1[LANE_W-1]);
        flag_c = ~diff[LANE_W];   // set when no borrow
        case (bus.ex_jump_cond_type)
            3'd0:    cond = flag_z;
            3'd1:    cond = ~flag_z;
            3'd4:    cond = flag_n ^ flag_v;
            3'd5:    cond = ~(flag_n ^ flag_v);
            3'd6:    cond = ~flag_c;
            3'd7:    cond = flag_c;
            default: cond = 1'b0;
        endcase
    end

    assign bus.ex_pc_src    = ((bus.ex_jump_cond & cond) | bus.ex_jump) & reset;
    assign bus.ex_pc_target = bus.ex_pc_target_src ? 32'(alu_res[LANE_W-1:0])
                                                   : bus.ex_pc + bus.ex_imm_ext;

    // multiply FSM
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          busy, bubble, capture, mul_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        bubble    = 1'b0;
        capture   = 1'b0;
        mul_load  = 1'b0;
        if (bus.mem_clear) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.ex_alu_control == OP_MUL) begin
                        busy      = 1'b1;
                        bubble    = 1'b1;
                        capture   = 1'b1;
                        state_nxt = S_BUSY;
                        cnt_nxt   = CNT_INIT;
                    end
                end
                S_BUSY: begin
                    if (cnt != '0) begin
                        // counts down regardless of mem_stall
                        busy    = 1'b1;
                        bubble  = 1'b1;
                        cnt_nxt = cnt - 1'b1;
                    end else begin
                        busy = bus.mem_stall;
                        if (!bus.mem_stall) begin
                            mul_load  = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.ex_busy = busy & reset;

    // Operands and control are captured at the start so forward sources may
    // change while the multiply is in flight.
    logic [W-1:0]  cap_op1, cap_op2, cap_sd, cap_imm;
    logic [31:0]   cap_instr, cap_pc_plus_4;
    logic          cap_reg_write, cap_mem_write, cap_mem_read, cap_vector_op;
    logic [1:0]    cap_result_src;
    logic [4:0]    cap_rd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_op1 <= '0; cap_op2 <= '0; cap_sd <= '0; cap_imm <= '0;
            cap_instr <= '0; cap_pc_plus_4 <= '0; cap_rd <= '0; cap_result_src <= '0;
            cap_reg_write <= 1'b0; cap_mem_write <= 1'b0;
            cap_mem_read <= 1'b0; cap_vector_op <= 1'b0;
        end else if (capture) begin
            cap_op1        <= op1;
            cap_op2        <= op2;
            cap_sd         <= store_data;
            cap_imm        <= imm_vec;
            cap_instr      <= bus.ex_instr;
            cap_pc_plus_4  <= bus.ex_pc_plus_4;
            cap_rd         <= bus.ex_rd;
            cap_result_src <= bus.ex_result_src;
            cap_reg_write  <= bus.ex_reg_write;
            cap_mem_write  <= bus.ex_mem_write;
            cap_mem_read   <= bus.ex_mem_read;
            cap_vector_op  <= bus.ex_vector_op;
        end
    end

    always_comb begin
        mul_res = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i == 0 || cap_vector_op)
                mul_res[i*LANE_W +: LANE_W] = cap_op1[i*LANE_W +: LANE_W] *
                                              cap_op2[i*LANE_W +: LANE_W];
        end
    end

    // EX/MEM register: clear > stall > bubble > load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || bus.mem_clear) begin
            bus.mem_instr      <= '0;
            bus.mem_reg_write  <= 1'b0;
            bus.mem_mem_write  <= 1'b0;
            bus.mem_mem_read   <= 1'b0;
            bus.mem_vector_op  <= 1'b0;
            bus.mem_result_src <= '0;
            bus.mem_alu_result <= '0;
            bus.mem_write_data <= '0;
            bus.mem_imm_ext    <= '0;
            bus.mem_pc_plus_4  <= '0;
            bus.mem_rd         <= '0;
        end else if (bus.mem_stall) begin
            bus.mem_instr      <= bus.mem_instr;
        end else if (bubble) begin
            // mem_instr keeps the last real instruction
            bus.mem_reg_write  <= 1'b0;
            bus.mem_mem_write  <= 1'b0;
            bus.mem_mem_read   <= 1'b0;
            bus.mem_vector_op  <= 1'b0;
            bus.mem_result_src <= '0;
            bus.mem_alu_result <= '0;
            bus.mem_write_data <= '0;
            bus.mem_imm_ext    <= '0;
            bus.mem_pc_plus_4  <= '0;
            bus.mem_rd         <= '0;
        end else if (mul_load) begin
            bus.mem_instr      <= cap_instr;
            bus.mem_reg_write  <= cap_reg_write;
            bus.mem_mem_write  <= cap_mem_write;
            bus.mem_mem_read   <= cap_mem_read;
            bus.mem_vector_op  <= cap_vector_op;
            bus.mem_result_src <= cap_result_src;
            bus.mem_alu_result <= mul_res;
            bus.mem_write_data <= cap_sd;
            bus.mem_imm_ext    <= cap_imm;
            bus.mem_pc_plus_4  <= cap_pc_plus_4;
            bus.mem_rd         <= cap_rd;
        end else begin
            bus.mem_instr      <= bus.ex_instr;
            bus.mem_reg_write  <= bus.ex_reg_write;
            bus.mem_mem_write  <= bus.ex_mem_write;
            bus.mem_mem_read   <= bus.ex_mem_read;
            bus.mem_vector_op  <= bus.ex_vector_op;
            bus.mem_result_src <= bus.ex_result_src;
            bus.mem_alu_result <= alu_res;
            bus.mem_write_data <= store_data;
            bus.mem_imm_ext    <= imm_vec;
            bus.mem_pc_plus_4  <= bus.ex_pc_plus_4;
            bus.mem_rd         <= bus.ex_rd;
        end
    end
endmodule

// File: tb/tb_stage_execute_vec.sv
// tb/tb_stage_execute_vec.sv - directed self-checking bench for stage_execute_vec
module tb_stage_execute_vec;
    localparam int LANES = 4, LANE_W = 32, MUL_LAT = 3, W = 128;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stage_execute_vec_if #(.W(W)) bus();

    stage_execute_vec #(.LANES(LANES), .LANE_W(LANE_W), .MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    `define CHK(tag, obs, exp) begin \
        n_chk++; \
        assert ((obs) === (exp)) else begin \
            n_fail++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

    function automatic logic [W-1:0] v4(input logic [31:0] l0, input logic [31:0] l1,
                                        input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [W-1:0] bc(input logic [31:0] x);
        return {4{x}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_reset_state(input string tag);
        n_chk++;
        if (bus.mem_alu_result !== {W{1'b0}} || bus.mem_reg_write !== 1'b0 ||
            bus.mem_instr !== 32'h0 || bus.ex_busy !== 1'b0 || bus.ex_pc_src !== 1'b0) begin
            n_fail++;
            $error("FAIL %s reset state: alu=%0h regw=%0b instr=%0h busy=%0b pcsrc=%0b",
                   tag, bus.mem_alu_result, bus.mem_reg_write, bus.mem_instr,
                   bus.ex_busy, bus.ex_pc_src);
        end
    endtask

    task automatic idle_inputs();
        bus.mem_clear = 1'b0;        bus.mem_stall = 1'b0;
        bus.ex_instr = '0;           bus.ex_reg_write = 1'b0;
        bus.ex_mem_write = 1'b0;     bus.ex_mem_read = 1'b0;
        bus.ex_jump = 1'b0;          bus.ex_jump_cond = 1'b0;
        bus.ex_vector_op = 1'b0;     bus.ex_jump_cond_type = '0;
        bus.ex_alu_control = '0;     bus.ex_alu_src_op1 = 1'b1;
        bus.ex_alu_src_op2 = 1'b0;   bus.ex_pc_target_src = 1'b0;
        bus.ex_result_src = '0;      bus.ex_pc = '0;
        bus.ex_pc_plus_4 = '0;       bus.ex_imm_ext = '0;
        bus.ex_rd1 = '0;             bus.ex_rd2 = '0;
        bus.ex_rd = '0;              bus.wb_result = '0;
        bus.ex_op1_forward = '0;     bus.ex_op2_forward = '0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        bus.ex_jump = 1'b1;
        bus.ex_alu_control = 4'd10;
        step(); step();
        expect_reset_state("rst");
        `CHK("rst_alu", bus.mem_alu_result, {W{1'b0}})
        `CHK("rst_regw", bus.mem_reg_write, 1'b0)
        `CHK("rst_instr", bus.mem_instr, 32'h0)
        `CHK("rst_busy", bus.ex_busy, 1'b0)
        `CHK("rst_pcsrc", bus.ex_pc_src, 1'b0)
        idle_inputs();
        reset = 1'b1;
        step();

        bus.ex_instr = 32'h11; bus.ex_reg_write = 1'b1; bus.ex_vector_op = 1'b1;
        bus.ex_alu_control = 4'd0; bus.ex_rd1 = bc(32'hFFFF_FFFF);
        bus.ex_rd2 = v4(0, 1, 2, 3); bus.ex_rd = 5'd5; bus.ex_imm_ext = 32'h10;
        bus.ex_result_src = 2'b01; bus.ex_pc_plus_4 = 32'h204;
        #1;
        `CHK("add_busy", bus.ex_busy, 1'b0)
        step();
        `CHK("add_alu", bus.mem_alu_result, v4(32'hFFFF_FFFF, 0, 1, 2))
        `CHK("add_rd", bus.mem_rd, 5'd5)
        `CHK("add_regw", bus.mem_reg_write, 1'b1)
        `CHK("add_wdata", bus.mem_write_data, v4(0, 1, 2, 3))
        `CHK("add_imm", bus.mem_imm_ext, bc(32'h10))
        `CHK("add_instr", bus.mem_instr, 32'h11)
        `CHK("add_rsrc", bus.mem_result_src, 2'b01)
        `CHK("add_pc4", bus.mem_pc_plus_4, 32'h204)

        bus.ex_vector_op = 1'b0; bus.ex_rd1 = v4(2, 9, 9, 9);
        bus.ex_alu_src_op2 = 1'b1; bus.ex_imm_ext = 32'd3;
        step();
        `CHK("sadd_alu", bus.mem_alu_result, v4(5, 0, 0, 0))

        bus.ex_op1_forward = 2'b10; bus.ex_rd1 = v4(32'h77, 1, 1, 1);
        bus.ex_rd2 = v4(7, 6, 8, 9); bus.ex_alu_src_op2 = 1'b0; bus.ex_alu_control = 4'd1;
        bus.ex_jump_cond = 1'b1; bus.ex_pc = 32'h100; bus.ex_imm_ext = 32'h40;
        bus.ex_jump_cond_type = 3'd5;
        #1;
        `CHK("bge_not", bus.ex_pc_src, 1'b0)
        bus.ex_jump_cond_type = 3'd4;
        #1;
        `CHK("blt_taken", bus.ex_pc_src, 1'b1)
        `CHK("blt_target", bus.ex_pc_target, 32'h140)
        step();
        `CHK("sub_alu", bus.mem_alu_result, v4(32'hFFFF_FFFE, 0, 0, 0))
        `CHK("sub_wdata", bus.mem_write_data, bc(32'd7))

        bus.ex_op1_forward = 2'b00; bus.ex_jump_cond = 1'b0; bus.ex_vector_op = 1'b1;
        bus.ex_alu_control = 4'd7; bus.ex_alu_src_op2 = 1'b1; bus.ex_imm_ext = 32'd4;
        bus.ex_rd1 = v4(32'h8000_0000, 32'h7FFF_FFFF, 32'hF0, 32'h8000_0001);
        step();
        `CHK("sra_alu", bus.mem_alu_result, v4(32'hF800_0000, 32'h07FF_FFFF, 32'hF, 32'hF800_0000))

        bus.ex_alu_control = 4'd9; bus.ex_alu_src_op2 = 1'b0;
        bus.ex_rd1 = v4(1, 32'hFFFF_FFFF, 5, 0); bus.ex_rd2 = v4(2, 1, 5, 0);
        step();
        `CHK("sltu_alu", bus.mem_alu_result, v4(1, 0, 0, 0))
        bus.ex_alu_control = 4'd8;
        step();
        `CHK("slt_alu", bus.mem_alu_result, v4(1, 1, 0, 0))

        bus.ex_alu_control = 4'd10; bus.ex_op1_forward = 2'b01; bus.wb_result = bc(32'd3);
        bus.ex_rd2 = bc(32'd4); bus.ex_rd = 5'd9; bus.ex_instr = 32'h22;
        #1;
        `CHK("mul_busy0", bus.ex_busy, 1'b1)
        step();
        `CHK("mul_busy1", bus.ex_busy, 1'b1)
        `CHK("mul_bub1_alu", bus.mem_alu_result, {W{1'b0}})
        `CHK("mul_bub1_regw", bus.mem_reg_write, 1'b0)
        bus.wb_result = bc(32'd7);
        step();
        `CHK("mul_busy2", bus.ex_busy, 1'b0)
        `CHK("mul_bub2_alu", bus.mem_alu_result, {W{1'b0}})
        step();
        `CHK("mul_alu", bus.mem_alu_result, bc(32'd12))
        `CHK("mul_rd", bus.mem_rd, 5'd9)
        `CHK("mul_regw", bus.mem_reg_write, 1'b1)
        `CHK("mul_instr", bus.mem_instr, 32'h22)

        bus.ex_op1_forward = 2'b00; bus.ex_rd1 = bc(32'd5); bus.ex_rd2 = bc(32'd6);
        bus.ex_rd = 5'd10; bus.ex_instr = 32'h33; bus.mem_stall = 1'b1;
        #1;
        `CHK("stl_busy0", bus.ex_busy, 1'b1)
        step();
        `CHK("stl_busy1", bus.ex_busy, 1'b1)
        `CHK("stl_hold1", bus.mem_alu_result, bc(32'd12))
        step();
        `CHK("stl_busy2", bus.ex_busy, 1'b1)
        step();
        `CHK("stl_busy3", bus.ex_busy, 1'b1)
        `CHK("stl_hold3", bus.mem_alu_result, bc(32'd12))
        step();
        bus.mem_stall = 1'b0;
        #1;
        n_chk++;
        if (bus.ex_busy !== 1'b0) begin
            n_fail++;
            $error("FAIL stl_busy_drop: wait expired but ex_busy=%0b", bus.ex_busy);
        end
        `CHK("stl_hold4", bus.mem_alu_result, bc(32'd12))
        step();
        `CHK("stl_alu", bus.mem_alu_result, bc(32'd30))
        `CHK("stl_rd", bus.mem_rd, 5'd10)

        bus.ex_rd1 = bc(32'd2); bus.ex_rd2 = bc(32'd2); bus.ex_rd = 5'd11;
        step();
        `CHK("clr_busy1", bus.ex_busy, 1'b1)
        bus.mem_clear = 1'b1;
        #1;
        `CHK("clr_busy_forced", bus.ex_busy, 1'b0)
        step();
        `CHK("clr_alu", bus.mem_alu_result, {W{1'b0}})
        `CHK("clr_regw", bus.mem_reg_write, 1'b0)
        `CHK("clr_instr", bus.mem_instr, 32'h0)
        `CHK("clr_rd", bus.mem_rd, 5'd0)
        bus.mem_clear = 1'b0; bus.ex_alu_control = 4'd3; bus.ex_rd = 5'd12;
        bus.ex_instr = 32'h44;
        #1;
        `CHK("clr_busy_next", bus.ex_busy, 1'b0)
        step();
        `CHK("clr_or_alu", bus.mem_alu_result, bc(32'd2))

        bus.ex_alu_control = 4'd10; bus.ex_rd1 = bc(32'd3); bus.ex_rd2 = bc(32'd3);
        bus.mem_stall = 1'b1;
        step();
        `CHK("rmul_busy", bus.ex_busy, 1'b1)
        `CHK("rmul_hold", bus.mem_alu_result, bc(32'd2))
        #2;
        reset = 1'b0;
        #1;
        expect_reset_state("rmul");
        `CHK("rmul_alu", bus.mem_alu_result, {W{1'b0}})
        `CHK("rmul_regw", bus.mem_reg_write, 1'b0)
        `CHK("rmul_rd", bus.mem_rd, 5'd0)
        `CHK("rmul_busy0", bus.ex_busy, 1'b0)
        idle_inputs();
        step();
        reset = 1'b1;

        bus.ex_rd1 = v4(32'hA0, 1, 1, 1); bus.ex_alu_src_op2 = 1'b1; bus.ex_imm_ext = 32'd5;
        step();
        `CHK("seed_a5", bus.mem_alu_result, v4(32'hA5, 0, 0, 0))
        bus.ex_mem_write = 1'b1; bus.ex_op2_forward = 2'b10;
        bus.ex_rd1 = v4(32'h1000, 7, 7, 7); bus.ex_rd2 = v4(1, 2, 3, 4); bus.ex_imm_ext = 32'd8;
        step();
        `CHK("st_wdata", bus.mem_write_data, bc(32'hA5))
        `CHK("st_addr", bus.mem_alu_result, v4(32'h1008, 0, 0, 0))
        `CHK("st_memw", bus.mem_mem_write, 1'b1)

        bus.ex_mem_write = 1'b0; bus.ex_op2_forward = 2'b00; bus.ex_alu_control = 4'd1;
        bus.ex_alu_src_op2 = 1'b0; bus.ex_rd1 = v4(32'h55, 0, 0, 0);
        bus.ex_rd2 = v4(32'h55, 0, 0, 0); bus.ex_jump_cond = 1'b1;
        bus.ex_jump_cond_type = 3'd7;
        #1;
        `CHK("bgeu_eq", bus.ex_pc_src, 1'b1)
        bus.ex_jump_cond_type = 3'd6;
        #1;
        `CHK("bltu_eq", bus.ex_pc_src, 1'b0)
        bus.ex_jump_cond_type = 3'd0;
        #1;
        `CHK("beq_eq", bus.ex_pc_src, 1'b1)
        bus.ex_jump_cond_type = 3'd2;
        #1;
        `CHK("type2_never", bus.ex_pc_src, 1'b0)
        bus.ex_rd1 = v4(32'h54, 0, 0, 0); bus.ex_jump_cond_type = 3'd6;
        #1;
        `CHK("bltu_lt", bus.ex_pc_src, 1'b1)
        bus.ex_jump_cond_type = 3'd7;
        #1;
        `CHK("bgeu_lt", bus.ex_pc_src, 1'b0)

        bus.ex_jump_cond = 1'b0; bus.ex_jump = 1'b1; bus.ex_pc_target_src = 1'b1;
        bus.ex_alu_control = 4'd0; bus.ex_rd1 = v4(32'h2000, 0, 0, 0);
        bus.ex_alu_src_op2 = 1'b1; bus.ex_imm_ext = 32'h10;
        #1;
        `CHK("jalr_src", bus.ex_pc_src, 1'b1)
        `CHK("jalr_target", bus.ex_pc_target, 32'h2010)

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
